// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
package riscv_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: op_supported = 1'b1;
      default:                          op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; timeout flags MEM_TIMEOUT cycles without ready.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign timeout = (cnt == W'(MEM_TIMEOUT));

  // Saturates at the limit so timeout stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!ready && !timeout) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback with memory
// timeout detection and a retired-instruction counter.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             PCSrc,
  output logic             RegWr,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q, state_d;
  logic [6:0] op_q;
  logic       retire;
  logic       timeout;
  logic       wait_clear;

  // The counter is held at zero outside the two waiting states, so it
  // always starts from zero when FETCH or MEM is entered.
  assign wait_clear = !((state_q == FETCH) || (state_q == MEM)) || mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Decoding is gated by rst so strobes drop asynchronously even though
  // the reset state itself (FETCH) would otherwise drive mem_req.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWr    = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    PCSrc    = 1'b0;
    RegWr    = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = ALUOP_ADD;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = HALT;
          end
        end
        DECODE: begin
          if (op_supported(opcode)) begin
            state_d = EXECUTE;
          end else begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        end
        EXECUTE: begin
          case (op_q)
            OP_R: begin
              ALUOp   = ALUOP_FUNCT;
              state_d = WRITEBACK;
            end
            OP_I: begin
              ALUOp   = ALUOP_FUNCT;
              ALUSrc  = 1'b1;
              state_d = WRITEBACK;
            end
            OP_LW, OP_SW: begin
              ALUSrc  = 1'b1;
              state_d = MEM;
            end
            OP_BEQ: begin
              ALUOp   = ALUOP_SUB;
              pc_we   = zero;
              PCSrc   = zero;
              retire  = 1'b1;
              state_d = FETCH;
            end
            default: state_d = FETCH;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          MemRead = (op_q == OP_LW);
          MemWr   = (op_q == OP_SW);
          if (mem_ready) begin
            if (op_q == OP_LW) begin
              state_d = WRITEBACK;
            end else begin
              retire  = 1'b1;
              state_d = FETCH;
            end
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = HALT;
          end
        end
        WRITEBACK: begin
          RegWr    = 1'b1;
          MemtoReg = (op_q == OP_LW);
          retire   = 1'b1;
          state_d  = FETCH;
        end
        HALT: halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemRead, MemWr, ir_we, pc_we, PCSrc;
  logic       RegWr, ALUSrc, MemtoReg, illegal, bus_err, halted;
  logic [1:0] ALUOp;
  logic [3:0] retired;
  logic [13:0] outs;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_ret;

  // Bit order: mem_req MemRead MemWr ir_we pc_we PCSrc RegWr ALUSrc MemtoReg
  //            ALUOp[1:0] illegal bus_err halted
  localparam logic [13:0] E_IDLE   = 14'h0000;
  localparam logic [13:0] E_FWAIT  = 14'h3000;
  localparam logic [13:0] E_FDONE  = 14'h3600;
  localparam logic [13:0] E_DEC    = 14'h0000;
  localparam logic [13:0] E_ILL    = 14'h0004;
  localparam logic [13:0] E_EXR    = 14'h0010;
  localparam logic [13:0] E_EXI    = 14'h0050;
  localparam logic [13:0] E_EXMEM  = 14'h0040;
  localparam logic [13:0] E_BEQT   = 14'h0308;
  localparam logic [13:0] E_BEQN   = 14'h0008;
  localparam logic [13:0] E_MEMLW  = 14'h3000;
  localparam logic [13:0] E_MEMSW  = 14'h2800;
  localparam logic [13:0] E_WB     = 14'h0080;
  localparam logic [13:0] E_WBLW   = 14'h00A0;
  localparam logic [13:0] E_BUSERR = 14'h3002;
  localparam logic [13:0] E_HALT   = 14'h0001;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPX = 7'b1111111;

  multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .zero     (zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .MemRead  (MemRead),
    .MemWr    (MemWr),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .PCSrc    (PCSrc),
    .RegWr    (RegWr),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .ALUOp    (ALUOp),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .halted   (halted),
    .retired  (retired)
  );

  assign outs = {mem_req, MemRead, MemWr, ir_we, pc_we, PCSrc, RegWr, ALUSrc,
                 MemtoReg, ALUOp, illegal, bus_err, halted};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: apply inputs, check decoded outputs, advance.
  task automatic cyc(input string tag, input logic [13:0] expv, input logic rdy,
                     input logic [6:0] op, input logic z);
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    #1;
    chk(tag, {18'd0, outs}, {18'd0, expv});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    chk(tag, {28'd0, retired}, {28'd0, exp_ret});
  endtask

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    exp_ret = '0;
    #1;
    chk("reset_outs", {18'd0, outs}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_outs_held", {18'd0, outs}, 32'd0);
    chk_ret("reset_retired");
    rst = 1'b0;

    // ADD, zero-wait: RegWr only in cycle 4
    cyc("add_fetch", E_FDONE, 1'b1, OPR, 1'b0);
    cyc("add_dec",   E_DEC,   1'b1, OPR, 1'b0);
    cyc("add_exe",   E_EXR,   1'b0, OPR, 1'b0);
    cyc("add_wb",    E_WB,    1'b0, OPR, 1'b0);
    exp_ret++; chk_ret("add_retired");

    // I-ALU
    cyc("addi_fetch", E_FDONE, 1'b1, OPI, 1'b0);
    cyc("addi_dec",   E_DEC,   1'b0, OPI, 1'b0);
    cyc("addi_exe",   E_EXI,   1'b0, OPI, 1'b0);
    cyc("addi_wb",    E_WB,    1'b0, OPI, 1'b0);
    exp_ret++; chk_ret("addi_retired");

    // LW with 3 wait cycles in MEM: 8 cycles total
    cyc("lw_fetch", E_FDONE, 1'b1, OPL, 1'b0);
    cyc("lw_dec",   E_DEC,   1'b0, OPL, 1'b0);
    cyc("lw_exe",   E_EXMEM, 1'b0, OPL, 1'b0);
    cyc("lw_mem0",  E_MEMLW, 1'b0, OPL, 1'b0);
    cyc("lw_mem1",  E_MEMLW, 1'b0, OPL, 1'b0);
    cyc("lw_mem2",  E_MEMLW, 1'b0, OPL, 1'b0);
    cyc("lw_mem3",  E_MEMLW, 1'b1, OPL, 1'b0);
    chk_ret("lw_not_yet_retired");
    cyc("lw_wb",    E_WBLW,  1'b0, OPL, 1'b0);
    exp_ret++; chk_ret("lw_retired");

    // SW zero-wait
    cyc("sw_fetch", E_FDONE, 1'b1, OPS, 1'b0);
    cyc("sw_dec",   E_DEC,   1'b0, OPS, 1'b0);
    cyc("sw_exe",   E_EXMEM, 1'b0, OPS, 1'b0);
    cyc("sw_mem",   E_MEMSW, 1'b1, OPS, 1'b0);
    exp_ret++; chk_ret("sw_retired");

    // BEQ taken, then not taken; mem_ready in DECODE/EXECUTE is ignored
    cyc("beq1_fetch", E_FDONE, 1'b1, OPB, 1'b1);
    cyc("beq1_dec",   E_DEC,   1'b1, OPB, 1'b1);
    cyc("beq1_exe",   E_BEQT,  1'b1, OPB, 1'b1);
    exp_ret++; chk_ret("beq1_retired");
    cyc("beq0_fetch", E_FDONE, 1'b1, OPB, 1'b0);
    cyc("beq0_dec",   E_DEC,   1'b0, OPB, 1'b0);
    cyc("beq0_exe",   E_BEQN,  1'b0, OPB, 1'b0);
    exp_ret++; chk_ret("beq0_retired");

    // Illegal opcode: one-cycle pulse, back to FETCH, no retire
    cyc("ill_fetch", E_FDONE, 1'b1, OPX, 1'b0);
    cyc("ill_dec",   E_ILL,   1'b0, OPX, 1'b0);
    chk_ret("ill_retired");

    // Ready arriving on the timeout cycle wins (already in FETCH here)
    cyc("race_w0", E_FWAIT, 1'b0, OPB, 1'b0);
    cyc("race_w1", E_FWAIT, 1'b0, OPB, 1'b0);
    cyc("race_w2", E_FWAIT, 1'b0, OPB, 1'b0);
    cyc("race_w3", E_FWAIT, 1'b0, OPB, 1'b0);
    cyc("race_rdy", E_FDONE, 1'b1, OPB, 1'b0);
    cyc("race_dec", E_DEC,   1'b0, OPB, 1'b0);
    cyc("race_exe", E_BEQN,  1'b0, OPB, 1'b0);
    exp_ret++; chk_ret("race_retired");

    // Counter wrap: 9 more BEQs take 7 -> 0
    for (int i = 0; i < 9; i++) begin
      cyc("wrap_fetch", E_FDONE, 1'b1, OPB, 1'b0);
      cyc("wrap_dec",   E_DEC,   1'b0, OPB, 1'b0);
      cyc("wrap_exe",   E_BEQN,  1'b0, OPB, 1'b0);
      exp_ret++;
      chk_ret("wrap_retired");
    end
    chk("wrap_zero", {28'd0, retired}, 32'd0);

    // FETCH timeout -> bus_err pulse -> HALT until reset
    cyc("to_w0", E_FWAIT,  1'b0, OPR, 1'b0);
    cyc("to_w1", E_FWAIT,  1'b0, OPR, 1'b0);
    cyc("to_w2", E_FWAIT,  1'b0, OPR, 1'b0);
    cyc("to_w3", E_FWAIT,  1'b0, OPR, 1'b0);
    cyc("to_err", E_BUSERR, 1'b0, OPR, 1'b0);
    cyc("halt0", E_HALT,   1'b1, OPR, 1'b0);
    cyc("halt1", E_HALT,   1'b1, OPR, 1'b0);
    cyc("halt2", E_HALT,   1'b0, OPR, 1'b0);
    rst = 1'b1;
    #1;
    chk("halt_rst_outs", {18'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = '0;
    chk_ret("halt_rst_retired");
    cyc("post_halt_fetch", E_FWAIT, 1'b0, OPS, 1'b0);

    // Async reset in the middle of SW MEM
    cyc("swr_fetch", E_FDONE, 1'b1, OPS, 1'b0);
    cyc("swr_dec",   E_DEC,   1'b0, OPS, 1'b0);
    cyc("swr_exe",   E_EXMEM, 1'b0, OPS, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("swr_mem", {18'd0, outs}, {18'd0, E_MEMSW});
    #2;
    rst = 1'b1;
    #1;
    chk("swr_rst_outs", {18'd0, outs}, 32'd0);
    chk_ret("swr_rst_retired");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("swr_add_fetch", E_FDONE, 1'b1, OPR, 1'b0);
    cyc("swr_add_dec",   E_DEC,   1'b0, OPR, 1'b0);
    cyc("swr_add_exe",   E_EXR,   1'b0, OPR, 1'b0);
    cyc("swr_add_wb",    E_WB,    1'b0, OPR, 1'b0);
    exp_ret++; chk_ret("swr_add_retired");
    cyc("final_fetch", E_FWAIT, 1'b0, OPR, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
